// File: rtl/breakout_pkg.sv
// Shared colour constants and hit-point to colour mapping for the breakout renderers.
package breakout_pkg;

  localparam int unsigned COLOR_W = 6;

  localparam logic [COLOR_W-1:0] COLOR_RED    = 6'b110000;
  localparam logic [COLOR_W-1:0] COLOR_YELLOW = 6'b111100;
  localparam logic [COLOR_W-1:0] COLOR_GREEN  = 6'b001100;
  localparam logic [COLOR_W-1:0] COLOR_WHITE  = 6'b111111;
  localparam logic [COLOR_W-1:0] COLOR_BLACK  = 6'b000000;

  // Full-strength blocks are red; the last two hit points fade to yellow then green.
  function automatic logic [COLOR_W-1:0] hp_color(input logic [7:0] hp, input logic [7:0] hp_max);
    logic [COLOR_W-1:0] c;
    c = COLOR_BLACK;
    if (hp == 8'd0)        c = COLOR_BLACK;
    else if (hp == hp_max) c = COLOR_RED;
    else if (hp == 8'd2)   c = COLOR_YELLOW;
    else if (hp == 8'd1)   c = COLOR_GREEN;
    else                   c = COLOR_WHITE;
    return c;
  endfunction

endpackage

// File: rtl/block_hp_store.sv
// Per-block hit-point storage with level load, single-block hit decrement and live count.
// Ports: clk, nRst (sync, active-low); load/load_hp fill every block; hit_valid/hit_idx
// decrement one block; hit_accepted/hit_destroyed pulse one cycle later; blocks_remaining
// and loaded are registered; rd_idx/rd_hp_c is a combinational read port for the renderer.
module block_hp_store
  import breakout_pkg::*;
#(
  parameter int unsigned NUM_BLOCKS = 208,
  parameter int unsigned HP_BITS    = 2,
  localparam int unsigned IDX_W     = $clog2(NUM_BLOCKS),
  localparam int unsigned CNT_W     = $clog2(NUM_BLOCKS + 1)
) (
  input  logic               clk,
  input  logic               nRst,
  input  logic               load,
  input  logic [HP_BITS-1:0] load_hp,
  input  logic               hit_valid,
  input  logic [IDX_W-1:0]   hit_idx,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [HP_BITS-1:0] rd_hp_c,
  output logic               hit_accepted,
  output logic               hit_destroyed,
  output logic [CNT_W-1:0]   blocks_remaining,
  output logic               loaded
);

  logic [HP_BITS-1:0] hp [NUM_BLOCKS];

  logic               hit_in_range_c;
  logic               rd_in_range_c;
  logic [HP_BITS-1:0] hit_hp_c;
  logic               hit_ok_c;

  // Range guards: the index width can address beyond the last block.
  always_comb begin
    hit_in_range_c = (IDX_W + 1)'(hit_idx) < (IDX_W + 1)'(NUM_BLOCKS);
    rd_in_range_c  = (IDX_W + 1)'(rd_idx) < (IDX_W + 1)'(NUM_BLOCKS);
    hit_hp_c       = hit_in_range_c ? hp[hit_idx] : '0;
    hit_ok_c       = hit_valid && (hit_hp_c != '0);
    rd_hp_c        = rd_in_range_c ? hp[rd_idx] : '0;
  end

  // Load has priority over a hit in the same cycle.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      for (int i = 0; i < int'(NUM_BLOCKS); i++) hp[i] <= '0;
      blocks_remaining <= '0;
      loaded           <= 1'b0;
      hit_accepted     <= 1'b0;
      hit_destroyed    <= 1'b0;
    end else begin
      hit_accepted  <= 1'b0;
      hit_destroyed <= 1'b0;
      if (load) begin
        for (int i = 0; i < int'(NUM_BLOCKS); i++) hp[i] <= load_hp;
        blocks_remaining <= (load_hp != '0) ? CNT_W'(NUM_BLOCKS) : '0;
        loaded           <= 1'b1;
      end else if (hit_ok_c) begin
        hp[hit_idx]  <= hit_hp_c - HP_BITS'(1);
        hit_accepted <= 1'b1;
        if (hit_hp_c == HP_BITS'(1)) begin
          hit_destroyed    <= 1'b1;
          blocks_remaining <= blocks_remaining - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/block_field_renderer.sv
// Breakout brick field renderer: tracks raster position within the block grid, looks up the
// hit points of the block under the beam and emits block_en/color one cycle after hpos/vpos.
// Ports: clk, nRst (sync, active-low); hpos/vpos/new_frame/new_line from VGA timing;
// load/load_hp and hit_valid/hit_idx update brick state; block_en/color to the mixer;
// hit_accepted/hit_destroyed pulses, blocks_remaining and all_cleared to game control.
module block_field_renderer
  import breakout_pkg::*;
#(
  parameter int unsigned BORDER_WIDTH   = 8,
  parameter int unsigned BLOCK_WIDTH    = 48,
  parameter int unsigned BLOCK_HEIGHT   = 16,
  parameter int unsigned BLOCKS_PER_ROW = 13,
  parameter int unsigned NUM_ROWS       = 16,
  parameter int unsigned GAP            = 1,
  parameter int unsigned HP_BITS        = 2,
  localparam int unsigned NUM_BLOCKS    = BLOCKS_PER_ROW * NUM_ROWS,
  localparam int unsigned IDX_W         = $clog2(NUM_BLOCKS),
  localparam int unsigned CNT_W         = $clog2(NUM_BLOCKS + 1)
) (
  input  logic               clk,
  input  logic               nRst,
  input  logic [9:0]         hpos,
  input  logic [8:0]         vpos,
  input  logic               new_frame,
  input  logic               new_line,
  input  logic               load,
  input  logic [HP_BITS-1:0] load_hp,
  input  logic               hit_valid,
  input  logic [IDX_W-1:0]   hit_idx,
  output logic               block_en,
  output logic [5:0]         color,
  output logic               hit_destroyed,
  output logic               hit_accepted,
  output logic [CNT_W-1:0]   blocks_remaining,
  output logic               all_cleared
);

  localparam int unsigned XW     = $clog2(BLOCK_WIDTH + 1);
  localparam int unsigned YW     = $clog2(BLOCK_HEIGHT + 1);
  localparam int unsigned COL_W  = $clog2(BLOCKS_PER_ROW + 1);
  localparam int unsigned ROW_W  = $clog2(NUM_ROWS + 1);
  localparam int unsigned BASE_W = IDX_W + 1;
  localparam int unsigned H_LO   = BORDER_WIDTH;
  localparam int unsigned H_HI   = BORDER_WIDTH + BLOCKS_PER_ROW * BLOCK_WIDTH;
  localparam int unsigned V_LO   = BORDER_WIDTH;
  localparam int unsigned V_HI   = BORDER_WIDTH + NUM_ROWS * BLOCK_HEIGHT;
  localparam int unsigned HP_MAX = (1 << HP_BITS) - 1;

  logic [XW-1:0]     x_cnt;
  logic [YW-1:0]     y_cnt;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [BASE_W-1:0] base;
  logic              line_sync;
  logic              frame_sync;

  logic               h_in_c;
  logic               v_in_c;
  logic               v_adv_c;
  logic [BASE_W-1:0]  idx_c;
  logic [HP_BITS-1:0] rd_hp_c;
  logic               draw_c;
  logic               loaded;

  // v_adv_c: the line that just ended was inside the field, so the row counters step.
  always_comb begin
    h_in_c  = (hpos >= 10'(H_LO)) && (hpos < 10'(H_HI));
    v_in_c  = (vpos >= 9'(V_LO)) && (vpos < 9'(V_HI));
    v_adv_c = (vpos > 9'(V_LO)) && (vpos <= 9'(V_HI));
    idx_c   = base + BASE_W'(col);
    draw_c  = frame_sync && h_in_c && v_in_c && (rd_hp_c != '0) &&
              (x_cnt < XW'(BLOCK_WIDTH - GAP)) && (y_cnt < YW'(BLOCK_HEIGHT - GAP));
  end

  // Raster counters; after reset they hold until the raster resynchronises.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      x_cnt      <= '0;
      col        <= '0;
      y_cnt      <= '0;
      row        <= '0;
      base       <= '0;
      line_sync  <= 1'b0;
      frame_sync <= 1'b0;
      block_en   <= 1'b0;
      color      <= COLOR_BLACK;
    end else begin
      if (new_line) begin
        x_cnt     <= '0;
        col       <= '0;
        line_sync <= 1'b1;
      end else if (line_sync && h_in_c) begin
        if (x_cnt == XW'(BLOCK_WIDTH - 1)) begin
          x_cnt <= '0;
          col   <= col + COL_W'(1);
        end else begin
          x_cnt <= x_cnt + XW'(1);
        end
      end

      if (new_frame) begin
        y_cnt      <= '0;
        row        <= '0;
        base       <= '0;
        frame_sync <= 1'b1;
      end else if (frame_sync && new_line && v_adv_c) begin
        if (y_cnt == YW'(BLOCK_HEIGHT - 1)) begin
          y_cnt <= '0;
          row   <= row + ROW_W'(1);
          base  <= base + BASE_W'(BLOCKS_PER_ROW);
        end else begin
          y_cnt <= y_cnt + YW'(1);
        end
      end

      block_en <= draw_c;
      color    <= draw_c ? hp_color(8'(rd_hp_c), 8'(HP_MAX)) : COLOR_BLACK;
    end
  end

  block_hp_store #(
    .NUM_BLOCKS (NUM_BLOCKS),
    .HP_BITS    (HP_BITS)
  ) u_hp_store (
    .clk              (clk),
    .nRst             (nRst),
    .load             (load),
    .load_hp          (load_hp),
    .hit_valid        (hit_valid),
    .hit_idx          (hit_idx),
    .rd_idx           (IDX_W'(idx_c)),
    .rd_hp_c          (rd_hp_c),
    .hit_accepted     (hit_accepted),
    .hit_destroyed    (hit_destroyed),
    .blocks_remaining (blocks_remaining),
    .loaded           (loaded)
  );

  assign all_cleared = loaded && (blocks_remaining == '0);

endmodule

// File: tb/tb_block_field_renderer.sv
module tb_block_field_renderer;

  localparam int NB = 208;
  localparam logic [5:0] RED = 6'b110000;
  localparam logic [5:0] YEL = 6'b111100;
  localparam logic [5:0] GRN = 6'b001100;

  logic       clk;
  logic       nRst;
  logic [9:0] hpos;
  logic [8:0] vpos;
  logic       new_frame;
  logic       new_line;
  logic       load;
  logic [1:0] load_hp;
  logic       hit_valid;
  logic [7:0] hit_idx;
  logic       block_en;
  logic [5:0] color;
  logic       hit_destroyed;
  logic       hit_accepted;
  logic [7:0] blocks_remaining;
  logic       all_cleared;

  block_field_renderer dut (
    .clk              (clk),
    .nRst             (nRst),
    .hpos             (hpos),
    .vpos             (vpos),
    .new_frame        (new_frame),
    .new_line         (new_line),
    .load             (load),
    .load_hp          (load_hp),
    .hit_valid        (hit_valid),
    .hit_idx          (hit_idx),
    .block_en         (block_en),
    .color            (color),
    .hit_destroyed    (hit_destroyed),
    .hit_accepted     (hit_accepted),
    .blocks_remaining (blocks_remaining),
    .all_cleared      (all_cleared)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       en;
    logic [5:0] color;
    logic       acc;
    logic       des;
    logic [7:0] rem;
    logic       clr;
  } exp_t;

  exp_t sb[$];

  int  pass_cnt = 0;
  int  chk_cnt  = 0;
  int  mhp [NB];
  int  mrem    = 0;
  bit  mloaded = 1'b0;
  int  en_seen = 0;
  int  en_after = 0;
  bit  after_rst = 1'b0;
  int  destroyed_cnt = 0;
  logic       l8_en  [640];
  logic [5:0] l8_col [640];
  logic       l24_en  [640];
  logic [5:0] l24_col [640];

  function automatic bit exp_pix(input int h, input int v, output int idx);
    int col, xo, row, yo;
    idx = 0;
    if (h < 8 || h >= 632 || v < 8 || v >= 264) return 1'b0;
    col = (h - 8) / 48;
    xo  = (h - 8) % 48;
    row = (v - 8) / 16;
    yo  = (v - 8) % 16;
    idx = row * 13 + col;
    return (mhp[idx] != 0) && (xo < 47) && (yo < 15);
  endfunction

  function automatic logic [5:0] exp_col(input int hp);
    case (hp)
      3:       return RED;
      2:       return YEL;
      1:       return GRN;
      default: return 6'b000000;
    endcase
  endfunction

  // Drive one cycle, push the model's prediction, then pop and compare after the edge.
  task automatic step(input int h, input int v, input bit nf, input bit nl, input bit rst,
                      input bit ld, input int lhp, input bit hv, input int hidx);
    exp_t e;
    exp_t got;
    int   idx;
    bit   on;
    hpos = 10'(h); vpos = 9'(v); new_frame = nf; new_line = nl; nRst = !rst;
    load = ld; load_hp = 2'(lhp); hit_valid = hv; hit_idx = 8'(hidx);
    e = '0;
    if (rst) begin
      for (int i = 0; i < NB; i++) mhp[i] = 0;
      mrem = 0; mloaded = 1'b0; after_rst = 1'b1;
    end else begin
      on = exp_pix(h, v, idx);
      e.en = on;
      e.color = on ? exp_col(mhp[idx]) : 6'b000000;
      if (ld) begin
        for (int i = 0; i < NB; i++) mhp[i] = lhp;
        mrem = (lhp != 0) ? NB : 0;
        mloaded = 1'b1;
      end else if (hv && hidx < NB && mhp[hidx] != 0) begin
        mhp[hidx] = mhp[hidx] - 1;
        e.acc = 1'b1;
        if (mhp[hidx] == 0) begin
          e.des = 1'b1;
          mrem = mrem - 1;
        end
      end
    end
    e.rem = 8'(mrem);
    e.clr = mloaded && (mrem == 0);
    sb.push_back(e);
    @(posedge clk); #1;
    got = sb.pop_front();
    chk_cnt++; if (block_en !== got.en) $display("FAIL pix_en (%0d,%0d) got %b exp %b", h, v, block_en, got.en); else pass_cnt++;
    chk_cnt++; if (color !== got.color) $display("FAIL pix_color (%0d,%0d) got %b exp %b", h, v, color, got.color); else pass_cnt++;
    chk_cnt++; if (hit_accepted !== got.acc) $display("FAIL hit_accepted (%0d,%0d) got %b exp %b", h, v, hit_accepted, got.acc); else pass_cnt++;
    chk_cnt++; if (hit_destroyed !== got.des) $display("FAIL hit_destroyed (%0d,%0d) got %b exp %b", h, v, hit_destroyed, got.des); else pass_cnt++;
    chk_cnt++; if (blocks_remaining !== got.rem) $display("FAIL blocks_remaining (%0d,%0d) got %0d exp %0d", h, v, blocks_remaining, got.rem); else pass_cnt++;
    chk_cnt++; if (all_cleared !== got.clr) $display("FAIL all_cleared (%0d,%0d) got %b exp %b", h, v, all_cleared, got.clr); else pass_cnt++;
    if (block_en === 1'b1) en_seen++;
    if (after_rst && block_en === 1'b1) en_after++;
    if (hit_destroyed === 1'b1) destroyed_cnt++;
    if (v == 8)  begin l8_en[h]  = block_en; l8_col[h]  = color; end
    if (v == 24) begin l24_en[h] = block_en; l24_col[h] = color; end
  endtask

  task automatic idle();
    step(639, 479, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_load(input int hp);
    step(639, 479, 0, 0, 0, 1, hp, 0, 0);
  endtask

  task automatic do_hit(input int idx);
    step(639, 479, 0, 0, 0, 0, 0, 1, idx);
  endtask

  // Full pixel lines only where the checks need them; other lines are a lone new_line cycle.
  task automatic run_frame(input int rst_line);
    for (int h = 0; h < 640; h++) begin
      l8_en[h] = 1'bx; l8_col[h] = 6'bx; l24_en[h] = 1'bx; l24_col[h] = 6'bx;
    end
    for (int v = 0; v < 480; v++) begin
      if (v == 8 || v == 23 || v == 24 || v == 100 || v == 263 || v == 264) begin
        for (int h = 0; h < 640; h++)
          step(h, v, (v == 0 && h == 0), (h == 0), (v == rst_line && h == 300), 0, 0, 0, 0);
      end else begin
        step(0, v, (v == 0), 1, 0, 0, 0, 0, 0);
      end
    end
    idle();
  endtask

  task automatic test_reset();
    step(639, 479, 0, 0, 1, 0, 0, 0, 0);
    step(639, 479, 0, 0, 1, 0, 0, 0, 0);
    chk_cnt++; if (block_en !== 1'b0 || color !== 6'd0) $display("FAIL reset_render got en=%b color=%b exp 0", block_en, color); else pass_cnt++;
    chk_cnt++; if (blocks_remaining !== 8'd0 || all_cleared !== 1'b0) $display("FAIL reset_count got rem=%0d clr=%b exp 0/0", blocks_remaining, all_cleared); else pass_cnt++;
    en_seen = 0;
    run_frame(-1);
    chk_cnt++; if (en_seen !== 0) $display("FAIL reset_frame_dark got %0d drawn pixels exp 0", en_seen); else pass_cnt++;
  endtask

  task automatic test_load_draw();
    do_load(3);
    chk_cnt++; if (blocks_remaining !== 8'd208) $display("FAIL load_remaining got %0d exp 208", blocks_remaining); else pass_cnt++;
    chk_cnt++; if (all_cleared !== 1'b0) $display("FAIL load_not_cleared got %b exp 0", all_cleared); else pass_cnt++;
    run_frame(-1);
    chk_cnt++; if (l8_en[8] !== 1'b1 || l8_col[8] !== RED) $display("FAIL pix_8_8 got en=%b color=%b exp 1/110000", l8_en[8], l8_col[8]); else pass_cnt++;
    chk_cnt++; if (l8_en[55] !== 1'b0) $display("FAIL gap_55_8 got %b exp 0", l8_en[55]); else pass_cnt++;
    chk_cnt++; if (l8_en[7] !== 1'b0 || l8_en[632] !== 1'b0) $display("FAIL edges_8 got %b/%b exp 0/0", l8_en[7], l8_en[632]); else pass_cnt++;
  endtask

  task automatic test_hit_seq();
    do_hit(15);
    run_frame(-1);
    chk_cnt++; if (l24_col[110] !== YEL) $display("FAIL hit1_yellow got %b exp %b", l24_col[110], YEL); else pass_cnt++;
    do_hit(15);
    run_frame(-1);
    chk_cnt++; if (l24_col[110] !== GRN) $display("FAIL hit2_green got %b exp %b", l24_col[110], GRN); else pass_cnt++;
    // Back-to-back on idx 14: each hit must see the previous one.
    do_hit(14);
    chk_cnt++; if (hit_accepted !== 1'b1 || hit_destroyed !== 1'b0) $display("FAIL b2b_hit1 got acc=%b des=%b exp 1/0", hit_accepted, hit_destroyed); else pass_cnt++;
    do_hit(14);
    chk_cnt++; if (hit_accepted !== 1'b1 || hit_destroyed !== 1'b0) $display("FAIL b2b_hit2 got acc=%b des=%b exp 1/0", hit_accepted, hit_destroyed); else pass_cnt++;
    do_hit(14);
    chk_cnt++; if (hit_destroyed !== 1'b1 || blocks_remaining !== 8'd207) $display("FAIL b2b_hit3 got des=%b rem=%0d exp 1/207", hit_destroyed, blocks_remaining); else pass_cnt++;
    do_hit(14);
    chk_cnt++; if (hit_accepted !== 1'b0 || hit_destroyed !== 1'b0) $display("FAIL hit4_ignored got acc=%b des=%b exp 0/0", hit_accepted, hit_destroyed); else pass_cnt++;
    run_frame(-1);
    chk_cnt++; if (l24_en[60] !== 1'b0) $display("FAIL destroyed_not_drawn got %b exp 0", l24_en[60]); else pass_cnt++;
    chk_cnt++; if (l24_col[8] !== RED) $display("FAIL neighbour_red got %b exp %b", l24_col[8], RED); else pass_cnt++;
  endtask

  task automatic test_oor_collision();
    do_hit(208);
    chk_cnt++; if (hit_accepted !== 1'b0 || blocks_remaining !== 8'd207) $display("FAIL oor_hit got acc=%b rem=%0d exp 0/207", hit_accepted, blocks_remaining); else pass_cnt++;
    step(639, 479, 0, 0, 0, 1, 2, 1, 5);
    chk_cnt++; if (hit_accepted !== 1'b0 || blocks_remaining !== 8'd208) $display("FAIL load_hit_collide got acc=%b rem=%0d exp 0/208", hit_accepted, blocks_remaining); else pass_cnt++;
    run_frame(-1);
    chk_cnt++; if (l8_col[300] !== YEL || l24_col[60] !== YEL) $display("FAIL collide_all_loaded got %b/%b exp %b", l8_col[300], l24_col[60], YEL); else pass_cnt++;
  endtask

  task automatic test_clear_all();
    do_load(1);
    destroyed_cnt = 0;
    for (int i = 0; i < NB; i++) begin
      do_hit(i);
      if (i == NB - 2) begin
        chk_cnt++; if (all_cleared !== 1'b0) $display("FAIL clear_early got %b exp 0", all_cleared); else pass_cnt++;
      end
    end
    chk_cnt++; if (all_cleared !== 1'b1) $display("FAIL clear_after_last got %b exp 1", all_cleared); else pass_cnt++;
    chk_cnt++; if (destroyed_cnt !== NB) $display("FAIL clear_pulses got %0d exp %0d", destroyed_cnt, NB); else pass_cnt++;
    idle();
  endtask

  task automatic test_reset_mid_frame();
    do_load(3);
    en_after = 0;
    after_rst = 1'b0;
    run_frame(100);
    chk_cnt++; if (en_after !== 0) $display("FAIL mid_reset_dark got %0d drawn pixels exp 0", en_after); else pass_cnt++;
    chk_cnt++; if (blocks_remaining !== 8'd0 || all_cleared !== 1'b0) $display("FAIL mid_reset_state got rem=%0d clr=%b exp 0/0", blocks_remaining, all_cleared); else pass_cnt++;
    run_frame(-1);
    chk_cnt++; if (en_after !== 0) $display("FAIL no_load_dark got %0d drawn pixels exp 0", en_after); else pass_cnt++;
    do_load(3);
    run_frame(-1);
    chk_cnt++; if (l8_en[8] !== 1'b1 || l8_col[8] !== RED || l8_en[55] !== 1'b0) $display("FAIL realign_row0 got %b/%b/%b exp 1/110000/0", l8_en[8], l8_col[8], l8_en[55]); else pass_cnt++;
    chk_cnt++; if (l24_en[56] !== 1'b1 || l24_en[103] !== 1'b0) $display("FAIL realign_row1 got %b/%b exp 1/0", l24_en[56], l24_en[103]); else pass_cnt++;
  endtask

  initial begin
    nRst = 1'b0; hpos = '0; vpos = '0; new_frame = 1'b0; new_line = 1'b0;
    load = 1'b0; load_hp = '0; hit_valid = 1'b0; hit_idx = '0;
    for (int i = 0; i < NB; i++) mhp[i] = 0;
    test_reset();
    test_load_draw();
    test_hit_seq();
    test_oor_collision();
    test_clear_all();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
